// File: rtl/rca8_signed_serial_sub.sv
// Bit-serial signed subtractor: Diff = A - B - Bin, one bit per clock, LSB first.
// A single full-adder cell adds A + ~B + ~Bin; the carry flop carries between bits.
// Start/Busy/Done handshake; Diff, Bout and V are registered and held between ops.
// Optional macro SUB_SAT_EN: clamp Diff to the signed range when V is set.
//
// state | meaning
// IDLE  | waiting for Start
// RUN   | one operand bit processed per clock, Busy=1
// DONE  | Done pulse cycle; a new Start is accepted here
module rca8_signed_serial_sub #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Bin,
  output logic         Busy,
  output logic         Done,
  output logic [N-1:0] Diff,
  output logic         Bout,
  output logic         V
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST   = CW'(N - 1);
  localparam logic [CW-1:0] PENULT = CW'(N - 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [N-1:0]   a_sh;
  logic [N-1:0]   b_sh;
  logic [N-2:0]   res_sh;
  logic [CW-1:0]  cnt;
  logic           c;
  logic           c_msb_in;

  logic           a_bit;
  logic           nb_bit;
  logic           d_bit;
  logic           c_out;
  logic [N-1:0]   assembled;

  // Full-adder cell on the current operand bits (B inverted for subtraction)
  assign a_bit     = a_sh[0];
  assign nb_bit    = ~b_sh[0];
  assign d_bit     = a_bit ^ nb_bit ^ c;
  assign c_out     = (a_bit & nb_bit) | (c & (a_bit ^ nb_bit));
  assign assembled = {d_bit, res_sh};

  // Handshake FSM, serial datapath and registered results
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Diff     <= '0;
      Bout     <= 1'b0;
      V        <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      cnt      <= '0;
      c        <= 1'b0;
      c_msb_in <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          Done <= 1'b0;
          if (Start) begin
            a_sh   <= A;
            b_sh   <= B;
            c      <= ~Bin;
            cnt    <= '0;
            res_sh <= '0;
            Busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          c      <= c_out;
          res_sh <= assembled[N-1:1];
          cnt    <= cnt + CW'(1);
          if (cnt == PENULT) c_msb_in <= c_out;
          if (cnt == LAST) begin
            Busy  <= 1'b0;
            Done  <= 1'b1;
            Bout  <= ~c_out;
            V     <= c_out ^ c_msb_in;
            state <= DONE;
`ifdef SUB_SAT_EN
            // On overflow the minuend's sign tells which rail was crossed
            if (c_out ^ c_msb_in)
              Diff <= a_bit ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
            else
              Diff <= assembled;
`else
            Diff <= assembled;
`endif
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca8_signed_serial_sub.sv
// Bench for rca8_signed_serial_sub (N=8): an arithmetic/timeline model checked on
// every falling edge, plus directed vectors with literal expected results.
module tb_rca8_signed_serial_sub;

  localparam int N = 8;
`ifdef SUB_SAT_EN
  localparam logic [7:0] NEG_OVF = 8'h80;
  localparam logic [7:0] POS_OVF = 8'h7F;
  localparam logic [7:0] BIG_OVF = 8'h80;
`else
  localparam logic [7:0] NEG_OVF = 8'h7F;
  localparam logic [7:0] POS_OVF = 8'h80;
  localparam logic [7:0] BIG_OVF = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       rst, Start, Bin;
  logic [7:0] A, B;
  logic       Busy, Done, Bout, V;
  logic [7:0] Diff;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  rca8_signed_serial_sub #(.N(N)) dut (
    .clk(clk), .rst(rst), .Start(Start), .A(A), .B(B), .Bin(Bin),
    .Busy(Busy), .Done(Done), .Diff(Diff), .Bout(Bout), .V(V)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: {bout, v, diff} from plain integer arithmetic
  function automatic logic [9:0] ref_sub(input logic [7:0] a, input logic [7:0] b,
                                         input logic bin);
    int s;
    logic [7:0] d;
    logic bo, ov;
    s  = int'($signed(a)) - int'($signed(b)) - int'(bin);
    d  = 8'(s);
    bo = (int'(a) < int'(b) + int'(bin));
    ov = (s > 127) || (s < -128);
`ifdef SUB_SAT_EN
    if (ov) d = (s < 0) ? 8'h80 : 8'h7F;
`endif
    return {bo, ov, d};
  endfunction

  // Timeline model: accept when idle, result appears N edges after accept
  logic       m_busy, m_done, m_bout, m_v;
  logic [7:0] m_diff;
  logic [9:0] m_pend;
  int         m_cyc;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_diff <= 8'h00; m_bout <= 1'b0; m_v <= 1'b0;
      m_cyc  <= 0;
    end else if (!m_busy && Start) begin
      m_busy <= 1'b1; m_done <= 1'b0; m_cyc <= 1;
      m_pend <= ref_sub(A, B, Bin);
    end else if (m_busy) begin
      if (m_cyc == N) begin
        m_busy <= 1'b0; m_done <= 1'b1;
        {m_bout, m_v, m_diff} <= m_pend;
      end else begin
        m_cyc <= m_cyc + 1;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_busy", Busy, m_busy);
      chk("model_done", Done, m_done);
      chk("model_diff", Diff, m_diff);
      chk("model_bout", Bout, m_bout);
      chk("model_v",    V,    m_v);
    end
  end

  task automatic wait_done(input bit drop, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (drop) Start = 1'b0;
    end while (Done !== 1'b1 && k < 20);
    chk("done_seen", Done, 1'b1);
  endtask

  task automatic run_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                        input logic bin, input logic [7:0] ed, input logic eb,
                        input logic ev);
    int k;
    A = a; B = b; Bin = bin; Start = 1'b1;
    wait_done(1'b1, k);
    chk({nm, "_lat"},  k, 9);
    chk({nm, "_diff"}, Diff, ed);
    chk({nm, "_bout"}, Bout, eb);
    chk({nm, "_v"},    V, ev);
  endtask

  initial begin
    int k;
    bit seen;
    rst = 1'b1; Start = 1'b0; A = 8'h00; B = 8'h00; Bin = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_diff", Diff, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    run_op("5m3",    8'h05, 8'h03, 1'b0, 8'h02,   1'b0, 1'b0);
    run_op("3m5",    8'h03, 8'h05, 1'b0, 8'hFE,   1'b1, 1'b0);
    run_op("m128m1", 8'h80, 8'h01, 1'b0, NEG_OVF, 1'b0, 1'b1);
    run_op("127mm1", 8'h7F, 8'hFF, 1'b0, POS_OVF, 1'b1, 1'b1);
    run_op("0m0b1",  8'h00, 8'h00, 1'b1, 8'hFF,   1'b1, 1'b0);
    run_op("big",    8'h80, 8'h7F, 1'b1, BIG_OVF, 1'b0, 1'b1);
    run_op("bin1",   8'h10, 8'h20, 1'b1, 8'hEF,   1'b1, 1'b0);
    repeat (2) @(negedge clk);

    // Start during Busy with new operands is ignored
    A = 8'h05; B = 8'h03; Bin = 1'b0; Start = 1'b1;
    @(negedge clk); Start = 1'b0;
    repeat (2) @(negedge clk);
    A = 8'h11; B = 8'h01; Start = 1'b1;
    chk("ign_busy", Busy, 1'b1);
    @(negedge clk); Start = 1'b0;
    wait_done(1'b1, k);
    chk("ign_lat",  k, 5);
    chk("ign_diff", Diff, 8'h02);
    @(negedge clk);

    // Start held high: back-to-back operations, Done every 9 cycles
    A = 8'h0A; B = 8'h04; Bin = 1'b0; Start = 1'b1;
    wait_done(1'b0, k);
    chk("b2b1_diff", Diff, 8'h06);
    A = 8'h14; B = 8'h1E;
    wait_done(1'b1, k);
    chk("b2b2_lat",  k, 9);
    chk("b2b2_diff", Diff, 8'hF6);
    chk("b2b2_bout", Bout, 1'b1);
    chk("b2b2_v",    V, 1'b0);
    @(negedge clk);

    // Reset during the 4th RUN cycle aborts the operation
    A = 8'h40; B = 8'h01; Bin = 1'b0; Start = 1'b1;
    @(negedge clk); Start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_pre", Busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", Busy, 1'b0);
    chk("abort_done", Done, 1'b0);
    chk("abort_diff", Diff, 8'h00);
    chk("abort_bout", Bout, 1'b0);
    chk("abort_v",    V, 1'b0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (Done === 1'b1) seen = 1'b1;
    end
    chk("abort_no_done", seen, 1'b0);

    run_op("post_rst", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rca8_signed_serial_sub.md
Name: rca8_signed_serial_sub

Overview:
- Bit-serial signed subtractor, Diff = A - B - Bin, one bit per clock, LSB first, through a single full-adder cell plus carry flop.
- Inverse operation and area-lean companion to the team's combinational signed ripple-carry adder.
- Used in the arithmetic lab datapath where subtract throughput is non-critical.
- Start/Busy/Done handshake; result, borrow and overflow are registered.

Parameters:
- N, 8, operand and result width in bits, two's complement; legal N >= 2.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  reset, synchronous, active-high.
- Start  input  1  request; sampled only when Busy=0.
- A  input  N  minuend, signed; captured on the accept edge.
- B  input  N  subtrahend, signed; captured on the accept edge.
- Bin  input  1  borrow-in at LSB; captured on the accept edge.
- Busy  output  1  high while bits are being processed.
- Done  output  1  one-cycle pulse, result valid.
- Diff  output  N  signed difference, registered.
- Bout  output  1  borrow-out at MSB (unsigned A < B+Bin).
- V  output  1  signed overflow.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State=IDLE; Busy=0, Done=0, Diff=0, Bout=0, V=0.
  - Internal shift registers, bit counter and carry cleared.
- FSM states IDLE, RUN, DONE.
- IDLE or DONE, with Start=1 at an edge (accept edge):
  - Latch A, B, Bin.
  - Carry flop c <= ~Bin.
  - Bit counter <= 0; go to RUN.
- Start=0 at that edge:
  - DONE goes to IDLE.
  - IDLE stays.
- RUN, each edge processes bit i = counter:
  - d_i = A[i] ^ ~B[i] ^ c.
  - c <= (A[i] & ~B[i]) | (c & (A[i] ^ ~B[i])).
  - d_i is shifted into the result register; counter increments.
  - Bit N-2's carry-out is retained as c_msb_in.
- Edge processing bit N-1:
  - Diff <= assembled result.
  - Bout <= ~carry_out(N-1).
  - V <= carry_out(N-1) ^ c_msb_in.
  - Go to DONE.
- Latency and output timing:
  - Busy=1 for exactly N cycles after the accept edge.
  - Done=1 for exactly one cycle, the N+1th cycle after the accept edge.
- Diff, Bout and V hold their values until the next completion or reset; they do not change during RUN.
- Start while Busy=1 is ignored; no queuing.
- Start in the DONE cycle is accepted: back-to-back operations, Done pulses every N+1 cycles.
- rst during RUN aborts the operation: no Done pulse, outputs forced to their reset values.
- Arithmetic is modulo 2^N; V flags when the true result lies outside [-2^(N-1), 2^(N-1)-1].

Optional Feature:
- Macro SUB_SAT_EN.
- Defined: on completion with V=1, Diff is clamped.
  - A[N-1]=0 gives 2^(N-1)-1 (0x7F for N=8).
  - A[N-1]=1 gives -2^(N-1) (0x80).
  - V and Bout still report the unclamped condition.
- Undefined: Diff is the wrap-around result; no clamp logic is synthesised.

Test Plan:
- N=8, A=5, B=3, Bin=0, Start pulse -> Busy high 8 cycles, Done pulse on cycle 9, Diff=0x02, Bout=0, V=0.
- A=3, B=5, Bin=0 -> Diff=0xFE (-2), Bout=1, V=0.
- A=0x80 (-128), B=0x01 -> V=1, Bout=0.
  - Without SUB_SAT_EN: Diff=0x7F.
  - With SUB_SAT_EN: Diff=0x80.
- A=0x7F, B=0xFF (-1) -> V=1, Bout=1.
  - Without SUB_SAT_EN: Diff=0x80.
  - With SUB_SAT_EN: Diff=0x7F.
- A=0, B=0, Bin=1 -> Diff=0xFF, Bout=1, V=0.
- Handshake and reset:
  - Start re-asserted with new operands during Busy is ignored; result matches the first operands.
  - Start held high through DONE gives back-to-back Done pulses 9 cycles apart.
  - rst asserted on the 4th RUN cycle -> Busy=0, no Done, Diff=0, Bout=0, V=0 next cycle.
